// File: rtl/mem_dbus_if_pkg.sv
// Shared constants, op encodings and FSM state type for the MEM-stage data-bus interface.
package mem_dbus_if_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned SEL_W      = 4;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALUOP_W    = 8;
    localparam int unsigned STALL_W    = 6;

    // Stall vector bit that gates the MEM/WB register
    localparam int unsigned STALL_MEM_WB = 4;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    localparam logic [DATA_W-1:0] ZeroWord = '0;

    localparam logic [ALUOP_W-1:0] EXE_LB_OP  = 8'hE0;
    localparam logic [ALUOP_W-1:0] EXE_LH_OP  = 8'hE1;
    localparam logic [ALUOP_W-1:0] EXE_LW_OP  = 8'hE3;
    localparam logic [ALUOP_W-1:0] EXE_LBU_OP = 8'hE4;
    localparam logic [ALUOP_W-1:0] EXE_LHU_OP = 8'hE5;
    localparam logic [ALUOP_W-1:0] EXE_SB_OP  = 8'hE8;
    localparam logic [ALUOP_W-1:0] EXE_SH_OP  = 8'hE9;
    localparam logic [ALUOP_W-1:0] EXE_SW_OP  = 8'hEB;

    typedef enum logic [1:0] {
        DBUS_IDLE = 2'b00,
        DBUS_WAIT = 2'b01,
        DBUS_HOLD = 2'b10
    } dbus_state_e;

    function automatic logic is_load_op(input logic [ALUOP_W-1:0] op);
        case (op)
            EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP, EXE_LHU_OP: return 1'b1;
            default:                                                 return 1'b0;
        endcase
    endfunction

    function automatic logic is_store_op(input logic [ALUOP_W-1:0] op);
        case (op)
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: return 1'b1;
            default:                         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Big-endian byte-lane steering: lane enables, replicated store data and extended load data.
module mem_lane_fmt
    import mem_dbus_if_pkg::*;
(
    input  logic [ALUOP_W-1:0] aluop,
    input  logic [1:0]         addr_lo,
    input  logic [DATA_W-1:0]  reg2,
    input  logic [DATA_W-1:0]  rdata,
    output logic [SEL_W-1:0]   sel,
    output logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed byte and halfword out of the read word (offset 0 = MSB)
    always_comb begin
        byte_lane = rdata[31:24];
        case (addr_lo)
            2'b00:   byte_lane = rdata[31:24];
            2'b01:   byte_lane = rdata[23:16];
            2'b10:   byte_lane = rdata[15:8];
            default: byte_lane = rdata[7:0];
        endcase
        half_lane = addr_lo[1] ? rdata[15:0] : rdata[31:16];
    end

    // Lane enables, store replication and load extension per op
    always_comb begin
        sel       = '0;
        wdata     = ZeroWord;
        load_data = ZeroWord;
        case (aluop)
            EXE_LB_OP: begin
                sel       = 4'b1000 >> addr_lo;
                load_data = {{24{byte_lane[7]}}, byte_lane};
            end
            EXE_LBU_OP: begin
                sel       = 4'b1000 >> addr_lo;
                load_data = {24'h000000, byte_lane};
            end
            EXE_LH_OP: begin
                sel       = addr_lo[1] ? 4'b0011 : 4'b1100;
                load_data = {{16{half_lane[15]}}, half_lane};
            end
            EXE_LHU_OP: begin
                sel       = addr_lo[1] ? 4'b0011 : 4'b1100;
                load_data = {16'h0000, half_lane};
            end
            EXE_LW_OP: begin
                sel       = '1;
                load_data = rdata;
            end
            EXE_SB_OP: begin
                sel   = 4'b1000 >> addr_lo;
                wdata = {4{reg2[7:0]}};
            end
            EXE_SH_OP: begin
                sel   = addr_lo[1] ? 4'b0011 : 4'b1100;
                wdata = {2{reg2[15:0]}};
            end
            EXE_SW_OP: begin
                sel   = '1;
                wdata = reg2;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_dbus_if.sv
// MEM-stage data-bus master: one req/ack transaction per load/store, stalling the pipe until done.
module mem_dbus_if
    import mem_dbus_if_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic [REG_ADDR_W-1:0] mem_wd,
    input  logic                  mem_wreg,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic [ALUOP_W-1:0]    mem_aluop,
    input  logic [ADDR_W-1:0]     mem_mem_addr,
    input  logic [DATA_W-1:0]     mem_reg2,
    input  logic [DATA_W-1:0]     dbus_rdata,
    input  logic                  dbus_ack,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [ADDR_W-1:0]     dbus_addr,
    output logic [SEL_W-1:0]      dbus_sel,
    output logic [DATA_W-1:0]     dbus_wdata,
    output logic [REG_ADDR_W-1:0] wb_wd,
    output logic                  wb_wreg,
    output logic [DATA_W-1:0]     wb_wdata,
    output logic                  stallreq
);

    dbus_state_e       state_q, state_d;
    logic              req_q,   req_d;
    logic              we_q,    we_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [SEL_W-1:0]  sel_q,   sel_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [SEL_W-1:0]  fmt_sel;
    logic [DATA_W-1:0] fmt_wdata;
    logic [DATA_W-1:0] fmt_load;
    logic              op_load;
    logic              op_store;

    // Only the MEM/WB advance bit matters here
    logic unused_stall;
    assign unused_stall = ^{stall[STALL_W-1:STALL_MEM_WB+1], stall[STALL_MEM_WB-1:0]};

    assign op_load  = is_load_op(mem_aluop);
    assign op_store = is_store_op(mem_aluop);

    mem_lane_fmt u_lane_fmt (
        .aluop     (mem_aluop),
        .addr_lo   (mem_mem_addr[1:0]),
        .reg2      (mem_reg2),
        .rdata     (dbus_rdata),
        .sel       (fmt_sel),
        .wdata     (fmt_wdata),
        .load_data (fmt_load)
    );

    // State and bus registers; reset takes priority over a coincident ack
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DBUS_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= ZeroWord;
            sel_q   <= '0;
            wdata_q <= ZeroWord;
            rdata_q <= ZeroWord;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state, bus register loads, stall request and MEM-stage result
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        stallreq = 1'b0;
        wb_wd    = mem_wd;
        wb_wreg  = mem_wreg;
        wb_wdata = mem_wdata;
        case (state_q)
            DBUS_IDLE: begin
                if (op_load || op_store) begin
                    req_d    = 1'b1;
                    we_d     = op_store;
                    addr_d   = {mem_mem_addr[ADDR_W-1:2], 2'b00};
                    sel_d    = fmt_sel;
                    wdata_d  = fmt_wdata;
                    stallreq = 1'b1;
                    state_d  = DBUS_WAIT;
                end
            end
            DBUS_WAIT: begin
                stallreq = 1'b1;
                if (dbus_ack) begin
                    req_d   = 1'b0;
                    rdata_d = fmt_load;
                    state_d = DBUS_HOLD;
                end
            end
            DBUS_HOLD: begin
                if (op_load) begin
                    wb_wdata = rdata_q;
                end
                if (stall[STALL_MEM_WB] == NoStop) begin
                    state_d = DBUS_IDLE;
                end
            end
            default: state_d = DBUS_IDLE;
        endcase
    end

    assign dbus_req   = req_q;
    assign dbus_we    = we_q;
    assign dbus_addr  = addr_q;
    assign dbus_sel   = sel_q;
    assign dbus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_dbus_if.sv
// Randomized self-checking bench for mem_dbus_if against a byte-arithmetic reference model.
module tb_mem_dbus_if;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_aluop;
    logic [31:0] mem_mem_addr;
    logic [31:0] mem_reg2;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stallreq;

    int checks = 0;
    int errors = 0;

    mem_dbus_if dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .mem_aluop    (mem_aluop),
        .mem_mem_addr (mem_mem_addr),
        .mem_reg2     (mem_reg2),
        .dbus_rdata   (dbus_rdata),
        .dbus_ack     (dbus_ack),
        .dbus_req     (dbus_req),
        .dbus_we      (dbus_we),
        .dbus_addr    (dbus_addr),
        .dbus_sel     (dbus_sel),
        .dbus_wdata   (dbus_wdata),
        .wb_wd        (wb_wd),
        .wb_wreg      (wb_wreg),
        .wb_wdata     (wb_wdata),
        .stallreq     (stallreq)
    );

    always #5 clk = ~clk;

    // Count request pulses (rising edges of dbus_req), sampled mid-cycle
    logic req_prev = 1'b0;
    int   req_rises = 0;
    always @(negedge clk) begin
        if (dbus_req && !req_prev) req_rises++;
        req_prev = dbus_req;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int op_size(input logic [7:0] op);
        case (op)
            8'hE0, 8'hE4, 8'hE8: return 1;
            8'hE1, 8'hE5, 8'hE9: return 2;
            8'hE3, 8'hEB:        return 4;
            default:             return 0;
        endcase
    endfunction

    function automatic bit op_is_store(input logic [7:0] op);
        return (op == 8'hE8) || (op == 8'hE9) || (op == 8'hEB);
    endfunction

    function automatic bit op_is_signed(input logic [7:0] op);
        return (op == 8'hE0) || (op == 8'hE1);
    endfunction

    // Byte index (0 = MSB) of the first accessed byte
    function automatic int op_start(input logic [7:0] op, input logic [31:0] addr);
        int sz = op_size(op);
        if (sz == 4) return 0;
        if (sz == 2) return addr[1] ? 2 : 0;
        return int'(addr[1:0]);
    endfunction

    function automatic logic [31:0] m_sel(input logic [7:0] op, input logic [31:0] addr);
        int sz = op_size(op);
        int st = op_start(op, addr);
        return 32'(((1 << sz) - 1) << (4 - st - sz));
    endfunction

    function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] reg2);
        case (op_size(op))
            1:       return {24'h0, reg2[7:0]} * 32'h01010101;
            2:       return {16'h0, reg2[15:0]} * 32'h00010001;
            default: return reg2;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        int     sz = op_size(op);
        int     st = op_start(op, addr);
        longint v;
        v = (longint'(rdata) >> (8 * (4 - st - sz))) & ((longint'(1) << (8 * sz)) - 1);
        if (op_is_signed(op) && v >= (longint'(1) << (8 * sz - 1)))
            v = v - (longint'(1) << (8 * sz));
        return v[31:0];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                            input logic [31:0] wdata, input logic [4:0] wd, input logic wreg);
        mem_aluop    = op;
        mem_mem_addr = addr;
        mem_reg2     = reg2;
        mem_wdata    = wdata;
        mem_wd       = wd;
        mem_wreg     = wreg;
    endtask

    // Non-memory op presented in IDLE: pass-through, no stall, no request
    task automatic nonmem(input string tag, input logic [7:0] op, input logic [31:0] wdata);
        logic [4:0] wd   = 5'($urandom);
        logic       wreg = 1'($urandom);
        @(posedge clk); #1;
        drive_op(op, $urandom, $urandom, wdata, wd, wreg);
        stall      = 6'($urandom);
        dbus_ack   = 1'($urandom);
        dbus_rdata = $urandom;
        #2;
        check({tag, "_wdata"}, wb_wdata, wdata);
        check({tag, "_wd"}, 32'(wb_wd), 32'(wd));
        check({tag, "_wreg"}, 32'(wb_wreg), 32'(wreg));
        check({tag, "_stallreq"}, 32'(stallreq), 32'd0);
        check({tag, "_req"}, 32'(dbus_req), 32'd0);
    endtask

    // Full load/store transaction: ack after `waits` wait cycles, MEM/WB stopped `stops` cycles
    task automatic txn(input string tag, input logic [7:0] op, input logic [31:0] addr,
                       input logic [31:0] reg2, input logic [31:0] alu_wdata,
                       input logic [31:0] rdata, input int waits, input int stops);
        logic [4:0]  wd   = 5'($urandom);
        logic        wreg = 1'($urandom);
        logic [31:0] exp_wb;
        int          stall_cycles = 0;
        int          rises0;
        logic [5:0]  sv;

        exp_wb = op_is_store(op) ? alu_wdata : m_load(op, addr, rdata);

        // T0: op appears in IDLE, ack is ignored here
        @(posedge clk); #1;
        rises0 = req_rises;
        drive_op(op, addr, reg2, alu_wdata, wd, wreg);
        stall      = 6'b0;
        dbus_ack   = 1'($urandom);
        dbus_rdata = $urandom;
        #2;
        check({tag, "_t0_stallreq"}, 32'(stallreq), 32'd1);
        if (stallreq) stall_cycles++;

        // Request phase
        for (int c = 0; c <= waits; c++) begin
            @(posedge clk); #1;
            dbus_ack   = (c == waits);
            dbus_rdata = (c == waits) ? rdata : $urandom;
            #2;
            if (stallreq) stall_cycles++;
            check({tag, "_req"}, 32'(dbus_req), 32'd1);
            check({tag, "_we"}, 32'(dbus_we), 32'(op_is_store(op)));
            check({tag, "_addr"}, dbus_addr, {addr[31:2], 2'b00});
            check({tag, "_sel"}, 32'(dbus_sel), m_sel(op, addr));
            if (op_is_store(op)) check({tag, "_bwdata"}, dbus_wdata, m_wdata(op, reg2));
        end

        // HOLD: result presented, stray acks ignored
        for (int h = 0; h <= stops; h++) begin
            @(posedge clk); #1;
            sv         = 6'($urandom);
            sv[4]      = (h < stops);
            stall      = sv;
            dbus_ack   = 1'($urandom);
            dbus_rdata = $urandom;
            #2;
            if (stallreq) stall_cycles++;
            check({tag, "_hold_wdata"}, wb_wdata, exp_wb);
            check({tag, "_hold_wd"}, 32'(wb_wd), 32'(wd));
            check({tag, "_hold_wreg"}, 32'(wb_wreg), 32'(wreg));
            check({tag, "_hold_stallreq"}, 32'(stallreq), 32'd0);
            check({tag, "_hold_req"}, 32'(dbus_req), 32'd0);
        end

        check({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(waits + 2));
        check({tag, "_req_pulses"}, 32'(req_rises - rises0), 32'd1);

        // Pipeline advanced: back in IDLE with the next (non-memory) op
        nonmem({tag, "_after"}, 8'h20 + 8'($urandom_range(0, 31)), $urandom);
    endtask

    // Reset while waiting for ack; optionally with ack coincident on the reset edge
    task automatic reset_in_wait(input string tag, input bit ack_with_rst);
        @(posedge clk); #1;
        drive_op(8'hE3, 32'h0000_0340, $urandom, $urandom, 5'd3, 1'b1);
        stall    = 6'b0;
        dbus_ack = 1'b0;
        @(posedge clk); #1;  // now in WAIT
        #2;
        check({tag, "_wait_req"}, 32'(dbus_req), 32'd1);
        rst        = 1'b1;
        dbus_ack   = ack_with_rst;
        dbus_rdata = $urandom;
        @(posedge clk); #1;
        rst = 1'b0;
        drive_op(8'h25, $urandom, $urandom, 32'h0000_1357, 5'd7, 1'b1);
        dbus_ack   = 1'b1;  // late ack
        dbus_rdata = $urandom;
        #2;
        check({tag, "_rst_req"}, 32'(dbus_req), 32'd0);
        check({tag, "_rst_stallreq"}, 32'(stallreq), 32'd0);
        check({tag, "_rst_addr"}, dbus_addr, 32'd0);
        check({tag, "_rst_sel"}, 32'(dbus_sel), 32'd0);
        check({tag, "_rst_wb"}, wb_wdata, 32'h0000_1357);
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        #2;
        check({tag, "_late_req"}, 32'(dbus_req), 32'd0);
        check({tag, "_late_stallreq"}, 32'(stallreq), 32'd0);
        check({tag, "_late_wb"}, wb_wdata, 32'h0000_1357);
    endtask

    localparam int NOPS = 8;
    logic [7:0] mem_ops [NOPS] = '{8'hE0, 8'hE1, 8'hE3, 8'hE4, 8'hE5, 8'hE8, 8'hE9, 8'hEB};

    initial begin
        rst        = 1'b1;
        stall      = 6'b0;
        dbus_ack   = 1'b0;
        dbus_rdata = '0;
        drive_op(8'h25, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
        @(posedge clk); #1;
        check("rst_req", 32'(dbus_req), 32'd0);
        check("rst_we", 32'(dbus_we), 32'd0);
        check("rst_addr", dbus_addr, 32'd0);
        check("rst_sel", 32'(dbus_sel), 32'd0);
        check("rst_wdata", dbus_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        check("rst_stallreq", 32'(stallreq), 32'd0);

        txn("lw",  8'hE3, 32'h0000_0100, $urandom, $urandom, 32'h8899_AABB, 2, 0);
        txn("lb",  8'hE0, 32'h0000_0103, $urandom, $urandom, 32'h11F2_3384, 0, 0);
        txn("lbu", 8'hE4, 32'h0000_0101, $urandom, $urandom, 32'h11F2_3384, 1, 0);
        txn("sb",  8'hE8, 32'h0000_0201, 32'h0000_00A5, $urandom, $urandom, 0, 0);
        txn("sh",  8'hE9, 32'h0000_0202, 32'h0000_1234, $urandom, $urandom, 1, 0);
        txn("lhu", 8'hE5, 32'h0000_0002, $urandom, $urandom, 32'h0000_BEEF, 0, 3);
        reset_in_wait("rstw", 1'b0);
        reset_in_wait("rstack", 1'b1);
        nonmem("nonmem", 8'h25, 32'h0000_CAFE);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0)
                nonmem("rnd_nm", 8'h20 + 8'($urandom_range(0, 31)), $urandom);
            else
                txn("rnd", mem_ops[$urandom_range(0, NOPS - 1)], $urandom, $urandom, $urandom,
                    $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
